// File: rtl/pwm_breath_multi_if.sv
// Control/status bundle for the multi-channel breathing PWM driver.
// The board controller drives modes, duty writes and timing dividers;
// the driver returns the LED outputs and the period marker.
interface pwm_breath_multi_if #(
  parameter int CH      = 4,
  parameter int PWM_W   = 10,
  parameter int PRESC_W = 8,
  parameter int STEP_W  = 8,
  parameter int CH_W    = 2
);
  logic [CH-1:0]      mode;
  logic               wr_en;
  logic [CH_W-1:0]    wr_ch;
  logic [PWM_W-1:0]   wr_duty;
  logic [PRESC_W-1:0] presc;
  logic [STEP_W-1:0]  step_div;
  logic [CH-1:0]      led;
  logic               period_start;

  modport master (
    output mode, wr_en, wr_ch, wr_duty, presc, step_div,
    input  led, period_start
  );

  modport slave (
    input  mode, wr_en, wr_ch, wr_duty, presc, step_div,
    output led, period_start
  );
endinterface

// File: rtl/pwm_breath_multi.sv
// Multi-channel LED PWM driver. One shared prescaler and PWM counter serve
// every channel; each channel shows either a written manual duty or a
// triangle "breathing" level. Duties only change at the period wrap so the
// LED waveforms never glitch mid-period.
module pwm_breath_multi #(
  parameter int CH      = 4,
  parameter int PWM_W   = 10,
  parameter int PRESC_W = 8,
  parameter int STEP_W  = 8,
  parameter int CH_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_breath_multi_if.slave bus
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [PRESC_W-1:0] pc_q, pc_d;
  logic [PWM_W-1:0]   cnt_q, cnt_d;
  logic [STEP_W-1:0]  sc_q, sc_d;
  logic               ps_q, ps_d;
  logic [CH-1:0]      led_q, led_d;
  logic [CH-1:0]      mode_q, mode_d;
  logic [PWM_W-1:0]   pending_q [CH];
  logic [PWM_W-1:0]   pending_d [CH];
  logic [PWM_W-1:0]   active_q  [CH];
  logic [PWM_W-1:0]   active_d  [CH];
  logic [PWM_W-1:0]   lvl_q     [CH];
  logic [PWM_W-1:0]   lvl_d     [CH];
  dir_e               dir_q     [CH];
  dir_e               dir_d     [CH];

  logic tick, wrap, step;
  logic [CH-1:0] mode_rise;

  // Shared timebase: prescaler, PWM counter, breathe step divider.
  always_comb begin
    tick  = (pc_q == bus.presc);
    pc_d  = tick ? '0 : pc_q + PRESC_W'(1);
    cnt_d = tick ? cnt_q + PWM_W'(1) : cnt_q;
    wrap  = tick && (cnt_q == '1);
    step  = wrap && (sc_q == bus.step_div);
    sc_d  = sc_q;
    if (wrap) begin
      sc_d = step ? '0 : sc_q + STEP_W'(1);
    end
    ps_d      = wrap;
    mode_d    = bus.mode;
    mode_rise = bus.mode & ~mode_q;
  end

  // Per-channel duty bookkeeping: writes, breathe ramp, wrap-time load, compare.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      pending_d[i] = pending_q[i];
      active_d[i]  = active_q[i];
      lvl_d[i]     = lvl_q[i];
      dir_d[i]     = dir_q[i];
      led_d[i]     = (cnt_q < active_q[i]);

      // Out-of-range channel indices match no channel and fall away.
      if (bus.wr_en && (bus.wr_ch == CH_W'(i))) begin
        pending_d[i] = bus.wr_duty;
      end

      // Entering breathe mode restarts the ramp and wins over a coincident step.
      if (mode_rise[i]) begin
        lvl_d[i] = '0;
        dir_d[i] = DIR_UP;
      end else if (step && bus.mode[i]) begin
        if (dir_q[i] == DIR_UP) begin
          if (lvl_q[i] == '1) begin
            dir_d[i] = DIR_DOWN;
            lvl_d[i] = lvl_q[i] - PWM_W'(1);
          end else begin
            lvl_d[i] = lvl_q[i] + PWM_W'(1);
          end
        end else begin
          if (lvl_q[i] == '0) begin
            dir_d[i] = DIR_UP;
            lvl_d[i] = PWM_W'(1);
          end else begin
            lvl_d[i] = lvl_q[i] - PWM_W'(1);
          end
        end
      end

      // Old pending is loaded here; a write in the wrap clk shows a period later.
      if (wrap) begin
        active_d[i] = bus.mode[i] ? lvl_d[i] : pending_q[i];
      end
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      cnt_q  <= '0;
      sc_q   <= '0;
      ps_q   <= 1'b0;
      led_q  <= '0;
      mode_q <= '0;
      for (int i = 0; i < CH; i++) begin
        pending_q[i] <= '0;
        active_q[i]  <= '0;
        lvl_q[i]     <= '0;
        dir_q[i]     <= DIR_UP;
      end
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      sc_q   <= sc_d;
      ps_q   <= ps_d;
      led_q  <= led_d;
      mode_q <= mode_d;
      for (int i = 0; i < CH; i++) begin
        pending_q[i] <= pending_d[i];
        active_q[i]  <= active_d[i];
        lvl_q[i]     <= lvl_d[i];
        dir_q[i]     <= dir_d[i];
      end
    end
  end

  assign bus.led          = led_q;
  assign bus.period_start = ps_q;

endmodule

// File: tb/tb_pwm_breath_multi.sv
// Bench for pwm_breath_multi with 3 channels and a 4-bit PWM counter.
module tb_pwm_breath_multi;
  localparam int CH      = 3;
  localparam int PWM_W   = 4;
  localparam int PRESC_W = 8;
  localparam int STEP_W  = 8;
  localparam int CH_W    = 2;
  localparam int NPER    = 1 << PWM_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchecks = 0;
  int   nerr = 0;
  int   hi [CH];
  int   wlen;

  always #5 clk = ~clk;

  pwm_breath_multi_if #(.CH(CH), .PWM_W(PWM_W), .PRESC_W(PRESC_W),
                        .STEP_W(STEP_W), .CH_W(CH_W)) bus ();

  pwm_breath_multi #(.CH(CH), .PWM_W(PWM_W), .PRESC_W(PRESC_W),
                     .STEP_W(STEP_W), .CH_W(CH_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int presc;
    int d0;
    int d1;
    int exp0;
    int exp1;
    int len;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int tri_lvl(input int k);
    int m;
    m = k % (2 * (NPER - 1));
    return (m <= NPER - 1) ? m : 2 * (NPER - 1) - m;
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.mode     = '0;
    bus.wr_en    = 1'b0;
    bus.wr_ch    = '0;
    bus.wr_duty  = '0;
    bus.presc    = '0;
    bus.step_div = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write(input int ch, input int duty);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = CH_W'(ch);
    bus.wr_duty = PWM_W'(duty);
    tick_clk();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_ps(input string name);
    int n = 0;
    while (bus.period_start !== 1'b1 && n < 500) begin
      tick_clk();
      n++;
    end
    check(name, int'(bus.period_start), 1);
  endtask

  // Starts on a period_start sample; accumulates LED-high clocks until the next one.
  task automatic count_until_ps();
    wlen = 0;
    for (int i = 0; i < CH; i++) hi[i] = 0;
    do begin
      for (int i = 0; i < CH; i++) hi[i] += int'(bus.led[i]);
      tick_clk();
      wlen++;
    end while (bus.period_start !== 1'b1 && wlen < 500);
  endtask

  task automatic count_n(input int n);
    for (int i = 0; i < CH; i++) hi[i] = 0;
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < CH; i++) hi[i] += int'(bus.led[i]);
      tick_clk();
    end
  endtask

  task automatic random_run(input int p, input int s, input int ncyc);
    int  m_pend [CH];
    int  m_act  [CH];
    int  m_k    [CH];
    bit  m_prev [CH];
    int  t, cnt, nwrap;
    bit  tk, wr, st, rise;
    logic [CH-1:0] exp_led;
    do_reset();
    bus.presc    = PRESC_W'(p);
    bus.step_div = STEP_W'(s);
    for (int i = 0; i < CH; i++) begin
      m_pend[i] = 0; m_act[i] = 0; m_k[i] = 0; m_prev[i] = 1'b0;
    end
    for (int c = 0; c < ncyc; c++) begin
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_ch   = CH_W'($urandom_range(0, 3));
      bus.wr_duty = PWM_W'($urandom_range(0, NPER - 1));
      if ($urandom_range(0, 59) == 0) begin
        int b = $urandom_range(0, CH - 1);
        bus.mode[b] = ~bus.mode[b];
      end
      // Timebase derived arithmetically from clocks since reset release.
      t     = c / (p + 1);
      tk    = ((c % (p + 1)) == p);
      cnt   = t % NPER;
      nwrap = t / NPER;
      wr    = tk && (cnt == NPER - 1);
      st    = wr && ((nwrap % (s + 1)) == s);
      for (int i = 0; i < CH; i++) exp_led[i] = (cnt < m_act[i]);
      for (int i = 0; i < CH; i++) begin
        rise = bus.mode[i] && !m_prev[i];
        if (rise) m_k[i] = 0;
        else if (st && bus.mode[i]) m_k[i]++;
        if (wr) m_act[i] = bus.mode[i] ? tri_lvl(m_k[i]) : m_pend[i];
        m_prev[i] = bus.mode[i];
      end
      if (bus.wr_en && int'(bus.wr_ch) < CH) m_pend[int'(bus.wr_ch)] = int'(bus.wr_duty);
      tick_clk();
      check("rand_led", int'(bus.led), int'(exp_led));
      check("rand_period_start", int'(bus.period_start), int'(wr));
    end
    bus.wr_en = 1'b0;
  endtask

  initial begin
    tbl[0] = '{presc: 0, d0: 5,  d1: 0, exp0: 5,  exp1: 0,  len: 16};
    tbl[1] = '{presc: 2, d0: 4,  d1: 0, exp0: 12, exp1: 0,  len: 48};
    tbl[2] = '{presc: 0, d0: 15, d1: 1, exp0: 15, exp1: 1,  len: 16};
    tbl[3] = '{presc: 1, d0: 8,  d1: 3, exp0: 16, exp1: 6,  len: 32};
    tbl[4] = '{presc: 3, d0: 0,  d1: 7, exp0: 0,  exp1: 28, len: 64};

    // Reset state
    do_reset();
    check("reset_led", int'(bus.led), 0);
    check("reset_period_start", int'(bus.period_start), 0);

    // Table-driven manual duty / prescaler vectors
    for (int v = 0; v < 5; v++) begin
      do_reset();
      bus.presc = PRESC_W'(tbl[v].presc);
      write(0, tbl[v].d0);
      write(1, tbl[v].d1);
      wait_ps("tbl_first_ps");
      count_until_ps();
      check("tbl_period_len", wlen, tbl[v].len);
      check("tbl_high_ch0", hi[0], tbl[v].exp0);
      check("tbl_high_ch1", hi[1], tbl[v].exp1);
      check("tbl_high_ch2", hi[2], 0);
    end

    // Asynchronous reset mid-period, then restart timing
    do_reset();
    write(0, 15);
    wait_ps("rst_pre_ps");
    repeat (3) tick_clk();
    check("rst_led_before", int'(bus.led[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_led_immediate", int'(bus.led), 0);
    check("rst_ps_immediate", int'(bus.period_start), 0);
    repeat (5) @(posedge clk);
    #1;
    check("rst_led_held", int'(bus.led), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int n = 0;
      do begin
        tick_clk();
        n++;
      end while (bus.period_start !== 1'b1 && n < 100);
      check("rst_first_ps_delay", n, 16);
    end

    // Write landing in the wrap clock
    do_reset();
    write(0, 3);
    wait_ps("coll_ps");
    repeat (15) tick_clk();
    bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_duty = 4'd9;
    tick_clk();
    bus.wr_en = 1'b0;
    check("coll_wrap_ps", int'(bus.period_start), 1);
    count_n(16);
    check("coll_next_period_old", hi[0], 3);
    count_n(16);
    check("coll_following_new", hi[0], 9);

    // Breathe triangle on channel 0
    do_reset();
    wait_ps("br_ps");
    repeat (5) tick_clk();
    bus.mode[0] = 1'b1;
    wait_ps("br_entry_ps");
    for (int k = 1; k <= 31; k++) begin
      count_until_ps();
      check($sformatf("breathe_k%0d", k), hi[0], tri_lvl(k));
    end

    // Invalid channel write and mode 1->0->1 on channel 1
    do_reset();
    write(0, 2);
    write(1, 6);
    write(2, 10);
    write(3, 13);
    wait_ps("inv_ps");
    count_until_ps();
    check("inv_ch0", hi[0], 2);
    check("inv_ch1", hi[1], 6);
    check("inv_ch2", hi[2], 10);
    repeat (4) tick_clk();
    bus.mode[1] = 1'b1;
    wait_ps("mix_ps1");
    for (int k = 1; k <= 3; k++) begin
      count_until_ps();
      check($sformatf("mix_breathe_%0d", k), hi[1], k);
    end
    repeat (4) tick_clk();
    bus.mode[1] = 1'b0;
    wait_ps("mix_ps2");
    count_until_ps();
    check("mix_manual_ch1", hi[1], 6);
    check("mix_manual_ch0", hi[0], 2);
    repeat (4) tick_clk();
    bus.mode[1] = 1'b1;
    wait_ps("mix_ps3");
    count_until_ps();
    check("mix_restart_1", hi[1], 1);
    count_until_ps();
    check("mix_restart_2", hi[1], 2);

    // Randomized stimulus against the reference model
    random_run($urandom_range(0, 2), $urandom_range(0, 2), 3000);
    random_run(0, 0, 2500);
    random_run(1, 2, 2500);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule

// File: doc/pwm_breath_multi.md
Name: pwm_breath_multi

Overview:
Parametrised multi-channel LED PWM driver, the successor to our single-channel fixed-duty LED dimmer. Each channel runs either manual duty (written over a simple write port) or automatic triangle "breathing" (duty ramps up and down continuously). A shared prescaler and PWM counter serve all channels. Duty changes take effect only at PWM period boundaries, so outputs are glitch-free. Sits between the board control logic and the LED pins.

Parameters:
CH, 4, number of independent LED channels (1..16)
PWM_W, 10, PWM counter and duty resolution in bits
PRESC_W, 8, width of the runtime prescaler value
STEP_W, 8, width of the runtime breathe-step divider
CH_W, 2, width of wr_ch; must satisfy 2^CH_W >= CH

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mode  in  CH  per-channel mode: 0 = manual, 1 = breathe
wr_en  in  1  single-cycle duty write strobe
wr_ch  in  CH_W  channel index for the write
wr_duty  in  PWM_W  manual duty value
presc  in  PRESC_W  PWM tick divider: one tick every presc+1 clks
step_div  in  STEP_W  breathe step every step_div+1 PWM periods
led  out  CH  PWM outputs, registered
period_start  out  1  one-clk pulse at each PWM period wrap

Behaviour:
- Reset (rst_n low, asynchronous): all counters, pending/active duties and breathe levels = 0; breathe directions = UP; led = 0; period_start = 0. Reset mid-period aborts the period immediately; after release, counting restarts from 0.
- Prescaler pc counts 0..presc. tick = (pc == presc), after which pc returns to 0. presc = 0 gives a tick every clk. If presc is lowered below the current pc, pc wraps naturally through 2^PRESC_W; the result is unspecified but must not corrupt other state.
- PWM counter cnt (PWM_W bits) increments on tick and wraps from 2^PWM_W-1 to 0. wrap = tick && cnt == all-ones.
- period_start is registered and asserted for exactly one clk in the cycle after wrap, when cnt == 0.
- Output: led[i] <= (cnt < active[i]), registered, one clk of latency from cnt. active = 0 holds led low constantly. The maximum on-fraction is (2^PWM_W-1)/2^PWM_W; 100% is not reachable by design.
- Write port:
  - When wr_en is high and wr_ch < CH, pending[wr_ch] <= wr_duty.
  - When wr_ch >= CH, the write is ignored.
  - Writes are accepted in either mode; pending is only used in manual mode.
- Step counter sc: increments on each wrap. step = wrap && sc == step_div, after which sc returns to 0.
- Breathe, per channel, on step, and only when mode[i] = 1:
  - UP: if lvl == all-ones, set dir = DOWN and lvl = lvl - 1; otherwise lvl = lvl + 1.
  - DOWN: if lvl == 0, set dir = UP and lvl = 1; otherwise lvl = lvl - 1.
  - This gives a full triangle period of 2*(2^PWM_W-1) steps with no repeated endpoint.
- Mode entry: a 0-to-1 edge on mode[i] (registered compare) forces lvl = 0 and dir = UP. This has priority over a step in the same clk.
- Active load, on wrap: active[i] <= mode[i] ? next lvl : pending[i].
  - "next lvl" is the value being written in that same edge, so a step and its load coincide.
  - A write landing in the same clk as wrap updates pending, but active takes the old pending value. The new value appears one period later.
- Mode 1-to-0: the channel takes pending at the next wrap. lvl and dir freeze until the next entry into breathe mode.
- Changes to step_div or presc take effect on the next comparison; no resynchronisation.

Test Plan:
- Reset: CH=2, PWM_W=4, presc=0. Hold rst_n low for 5 clks mid-count -> led=0, period_start=0 immediately; after release, first period_start is 16 clks later.
- Manual duty: write ch0=5, ch1=0 before first wrap -> per 16-clk period, led[0] high exactly 5 clks, led[1] never high; period_start spacing = 16.
- Prescaler: presc=2, ch0 duty=4 -> period = 48 clks, led[0] high 12 consecutive clks per period.
- Write/wrap collision: write ch0=9 in the wrap clk while active=3 -> next period high 3 clks, following period high 9.
- Breathe: PWM_W=4, step_div=0, mode[0] rises -> active[0] sequence per period 1,2,...,15,14,...,1,0,1; full triangle every 30 periods.
- Invalid/mixed: CH=3, wr_ch=3 write -> no channel changes. Toggle mode[1] 1→0→1 -> ch1 takes pending, then restarts breathe from level 0 direction UP.
